// File: rtl/branch_ctrl_pkg.sv
// Shared widths, opcodes and state encoding for the ID-stage branch controller.
package branch_ctrl_pkg;

  localparam int PC_WIDTH       = 32;
  localparam int OPCODE_WIDTH   = 6;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE = 6'h05;

  typedef enum logic [1:0] {
    BC_IDLE  = 2'd0,
    BC_STALL = 2'd1,
    BC_FLUSH = 2'd2
  } bc_state_e;

  // Only BEQ/BNE may redirect; any other opcode flagged as a branch resolves not-taken.
  function automatic logic is_cond_branch(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_ctrl_hazard.sv
// Combinational hazard check for a branch in ID: required stall count and
// EX/MEM-result forwarding selects for the comparator operands.
module branch_hazard_detect
  import branch_ctrl_pkg::*;
#(
  parameter int RA_WIDTH = REG_ADDR_WIDTH
) (
  input  logic [RA_WIDTH-1:0] i_id_rs,
  input  logic [RA_WIDTH-1:0] i_id_rt,
  input  logic                i_ex_regwrite,
  input  logic                i_ex_memread,
  input  logic [RA_WIDTH-1:0] i_ex_rd,
  input  logic                i_mem_regwrite,
  input  logic                i_mem_memread,
  input  logic [RA_WIDTH-1:0] i_mem_rd,
  output logic [1:0]          o_stall_n,
  output logic                o_fwd_a,
  output logic                o_fwd_b
);

  logic w_ex_dep;
  logic w_mem_dep;
  logic w_mem_alu;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign w_ex_dep  = (i_ex_rd  != '0) && ((i_ex_rd  == i_id_rs) || (i_ex_rd  == i_id_rt));
  assign w_mem_dep = (i_mem_rd != '0) && ((i_mem_rd == i_id_rs) || (i_mem_rd == i_id_rt));
  assign w_mem_alu = i_mem_regwrite && !i_mem_memread && (i_mem_rd != '0);

  // A load in EX needs two cycles before its data reaches the comparator; an ALU
  // result in EX or a load in MEM needs one.
  always_comb begin
    o_stall_n = 2'd0;
    if (i_ex_memread && i_ex_regwrite && w_ex_dep) begin
      o_stall_n = 2'd2;
    end else if ((i_ex_regwrite && w_ex_dep) || (i_mem_memread && w_mem_dep)) begin
      o_stall_n = 2'd1;
    end
  end

  assign o_fwd_a = w_mem_alu && (i_mem_rd == i_id_rs);
  assign o_fwd_b = w_mem_alu && (i_mem_rd == i_id_rt);

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencing: stalls on operand hazards, redirects the PC on a
// taken branch, flushes the wrong-path fetch and counts resolved/taken branches.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int RA_WIDTH  = REG_ADDR_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_id_branch,
  input  logic [OPCODE_WIDTH-1:0] i_id_opcode,
  input  logic [RA_WIDTH-1:0]     i_id_rs,
  input  logic [RA_WIDTH-1:0]     i_id_rt,
  input  logic                    i_ex_regwrite,
  input  logic                    i_ex_memread,
  input  logic [RA_WIDTH-1:0]     i_ex_rd,
  input  logic                    i_mem_regwrite,
  input  logic                    i_mem_memread,
  input  logic [RA_WIDTH-1:0]     i_mem_rd,
  input  logic                    i_compare,
  input  logic [PC_WIDTH-1:0]     i_target_pc,
  output logic                    o_stall,
  output logic                    o_bubble_idex,
  output logic                    o_fwd_a,
  output logic                    o_fwd_b,
  output logic                    o_pc_sel,
  output logic [PC_WIDTH-1:0]     o_branch_pc,
  output logic                    o_flush_ifid,
  output logic [CNT_WIDTH-1:0]    o_br_cnt,
  output logic [CNT_WIDTH-1:0]    o_taken_cnt,
  output logic [1:0]              o_dbg_state
);

  // Handshake note: there is no valid/ready pair here. i_id_branch qualifies the
  // ID slot each cycle; o_stall holds that slot until the branch resolves, and the
  // resolve cycle is the single cycle in IDLE with i_id_branch=1 and no hazard.

  bc_state_e            r_state;
  bc_state_e            w_state_next;
  logic [1:0]           r_scnt;
  logic [1:0]           w_scnt_next;
  logic [CNT_WIDTH-1:0] r_br_cnt;
  logic [CNT_WIDTH-1:0] r_taken_cnt;
  logic                 w_br_inc;
  logic                 w_taken_inc;
  logic [1:0]           w_stall_n;
  logic                 w_fwd_a;
  logic                 w_fwd_b;
  logic                 w_taken;

  branch_hazard_detect #(
    .RA_WIDTH(RA_WIDTH)
  ) u_hazard (
    .i_id_rs        (i_id_rs),
    .i_id_rt        (i_id_rt),
    .i_ex_regwrite  (i_ex_regwrite),
    .i_ex_memread   (i_ex_memread),
    .i_ex_rd        (i_ex_rd),
    .i_mem_regwrite (i_mem_regwrite),
    .i_mem_memread  (i_mem_memread),
    .i_mem_rd       (i_mem_rd),
    .o_stall_n      (w_stall_n),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b)
  );

  assign w_taken = i_compare && is_cond_branch(i_id_opcode);

  // State, stall counter and saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= BC_IDLE;
      r_scnt      <= 2'd0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_scnt  <= w_scnt_next;
      if (w_br_inc && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_WIDTH'(1);
      end
      if (w_taken_inc && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Next state and same-cycle control outputs; reset low forces every control output to 0.
  always_comb begin
    w_state_next  = r_state;
    w_scnt_next   = r_scnt;
    w_br_inc      = 1'b0;
    w_taken_inc   = 1'b0;
    o_stall       = 1'b0;
    o_bubble_idex = 1'b0;
    o_fwd_a       = 1'b0;
    o_fwd_b       = 1'b0;
    o_pc_sel      = 1'b0;
    o_branch_pc   = '0;
    o_flush_ifid  = 1'b0;
    unique case (r_state)
      BC_IDLE: begin
        if (i_id_branch) begin
          o_fwd_a = w_fwd_a;
          o_fwd_b = w_fwd_b;
          if (w_stall_n != 2'd0) begin
            o_stall       = 1'b1;
            o_bubble_idex = 1'b1;
            w_scnt_next   = w_stall_n - 2'd1;
            w_state_next  = (w_stall_n > 2'd1) ? BC_STALL : BC_IDLE;
          end else begin
            w_br_inc = 1'b1;
            if (w_taken) begin
              o_pc_sel     = 1'b1;
              o_branch_pc  = i_target_pc;
              o_flush_ifid = 1'b1;
              w_taken_inc  = 1'b1;
              w_state_next = BC_FLUSH;
            end
          end
        end
      end
      BC_STALL: begin
        // Hazard inputs are not re-evaluated: the count loaded in IDLE is final.
        o_stall       = 1'b1;
        o_bubble_idex = 1'b1;
        w_scnt_next   = (r_scnt != 2'd0) ? (r_scnt - 2'd1) : 2'd0;
        w_state_next  = (r_scnt <= 2'd1) ? BC_IDLE : BC_STALL;
      end
      BC_FLUSH: begin
        // The ID slot holds the squashed wrong-path instruction.
        w_state_next = BC_IDLE;
      end
      default: begin
        w_state_next = BC_IDLE;
      end
    endcase
    if (!i_rst) begin
      w_br_inc      = 1'b0;
      w_taken_inc   = 1'b0;
      o_stall       = 1'b0;
      o_bubble_idex = 1'b0;
      o_fwd_a       = 1'b0;
      o_fwd_b       = 1'b0;
      o_pc_sel      = 1'b0;
      o_branch_pc   = '0;
      o_flush_ifid  = 1'b0;
    end
  end

  assign o_br_cnt    = r_br_cnt;
  assign o_taken_cnt = r_taken_cnt;
  assign o_dbg_state = r_state;

endmodule
